// File: rtl/bcd_display_scanner_pkg.sv
// Shared definitions for the multiplexed three-digit BCD display scanner:
// scan states, digit slot indices and active-low g..a segment codes.
package bcd_display_scanner_pkg;

    typedef enum logic [2:0] {
        G_U,
        D_U,
        G_T,
        D_T,
        G_H,
        D_H
    } state_t;

    localparam int unsigned DIG_UNITS    = 0;
    localparam int unsigned DIG_TENS     = 1;
    localparam int unsigned DIG_HUNDREDS = 2;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic is_guard(input state_t s);
        return (s == G_U) || (s == G_T) || (s == G_H);
    endfunction

endpackage

// File: rtl/bcd_display_scanner_seg.sv
// Combinational BCD digit to active-low g..a segment decoder; non-BCD
// codes show a dash.
module bcd_to_seg
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (code_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed three-digit seven-segment scanner with guard gaps,
// double-buffered digits and optional leading-zero blanking.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned GUARD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hundreds_data,
    input  logic [3:0] tens_data,
    input  logic [3:0] units_data,
    input  logic       load,
    input  logic       lz_blank,
    output logic [7:0] seg_n,
    output logic [2:0] digit_en_n,
    output logic       frame_start
);

    localparam int unsigned MAXC = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0][3:0] pend_q, act_q;
    logic [7:0]      seg_q, seg_d;
    logic [2:0]      en_q, en_d;
    logic            fs_q, fs_d;

    logic            phase_last;
    logic            enter_gu;
    logic [3:0]      dig_sel;
    logic [6:0]      dec_seg;
    logic            blank;

    bcd_to_seg u_dec (
        .code_i (dig_sel),
        .seg_o  (dec_seg)
    );

    always_comb begin
        phase_last = is_guard(state_q) ? (cnt_q == CW'(GUARD_CYCLES - 1))
                                       : (cnt_q == CW'(DIGIT_CYCLES - 1));
        state_d = state_q;
        if (phase_last) begin
            case (state_q)
                G_U:     state_d = D_U;
                D_U:     state_d = G_T;
                G_T:     state_d = D_T;
                D_T:     state_d = G_H;
                G_H:     state_d = D_H;
                default: state_d = G_U;
            endcase
        end
        cnt_d    = phase_last ? '0 : cnt_q + CW'(1);
        enter_gu = phase_last && (state_q == D_H);
    end

    // Blanking looks at the active buffer and the live lz_blank each slot.
    always_comb begin
        dig_sel = '0;
        en_d    = '1;
        blank   = 1'b0;
        case (state_q)
            D_U: begin
                dig_sel = act_q[DIG_UNITS];
                en_d    = 3'b110;
            end
            D_T: begin
                dig_sel = act_q[DIG_TENS];
                en_d    = 3'b101;
                blank   = lz_blank && (act_q[DIG_HUNDREDS] == 4'd0)
                                   && (act_q[DIG_TENS] == 4'd0);
            end
            D_H: begin
                dig_sel = act_q[DIG_HUNDREDS];
                en_d    = 3'b011;
                blank   = lz_blank && (act_q[DIG_HUNDREDS] == 4'd0);
            end
            default: ;
        endcase
        seg_d = is_guard(state_q) ? 8'hFF : {1'b1, (blank ? SEG_BLANK : dec_seg)};
        fs_d  = (state_q == G_U) && (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= G_U;
            cnt_q   <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            seg_q   <= '1;
            en_q    <= '1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                pend_q <= {hundreds_data, tens_data, units_data};
            end
            if (enter_gu) begin
                act_q <= pend_q;
            end
            seg_q <= seg_d;
            en_q  <= en_d;
            fs_q  <= fs_d;
        end
    end

    assign seg_n       = seg_q;
    assign digit_en_n  = en_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with DIGIT_CYCLES=4, GUARD_CYCLES=2
// (18-cycle frames); outputs are sampled on the falling clock edge.
module tb_bcd_display_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] hundreds_data = '0;
    logic [3:0] tens_data = '0;
    logic [3:0] units_data = '0;
    logic       load = 1'b0;
    logic       lz_blank = 1'b0;
    logic [7:0] seg_n;
    logic [2:0] digit_en_n;
    logic       frame_start;

    int errors = 0;
    int checks = 0;

    bcd_display_scanner #(
        .DIGIT_CYCLES (4),
        .GUARD_CYCLES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hundreds_data (hundreds_data),
        .tens_data     (tens_data),
        .units_data    (units_data),
        .load          (load),
        .lz_blank      (lz_blank),
        .seg_n         (seg_n),
        .digit_en_n    (digit_en_n),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    // Output slot k of a frame: 0-1 guard, 2-5 units, 6-7 guard, 8-11 tens,
    // 12-13 guard, 14-17 hundreds.
    function automatic logic [11:0] exp_out(input int k, input logic [7:0] eu, et, eh);
        if (k >= 2 && k <= 5)   return {eu, 3'b110, 1'b0};
        if (k >= 8 && k <= 11)  return {et, 3'b101, 1'b0};
        if (k >= 14 && k <= 17) return {eh, 3'b011, 1'b0};
        return {8'hFF, 3'b111, (k == 0)};
    endfunction

    // Drive one cycle of inputs (sampled at the next rising edge), then
    // return at the following falling edge.
    task automatic tick(input bit ld, input logic [3:0] h, t, u, input bit lz);
        load          = ld;
        hundreds_data = h;
        tens_data     = t;
        units_data    = u;
        lz_blank      = lz;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({seg_n, digit_en_n, frame_start} !== {8'hFF, 3'b111, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", {seg_n, digit_en_n, frame_start}, {8'hFF, 3'b111, 1'b0});
        end
        reset = 1'b0;
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle_fs got=%b exp=0", frame_start);
        end
    endtask

    task automatic test_basic;
        logic [7:0] eu[2] = '{8'hC0, 8'h92};
        logic [7:0] et[2] = '{8'hC0, 8'h92};
        logic [7:0] eh[2] = '{8'hC0, 8'hA4};
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 18; k++) begin
                tick(f == 0 && k == 3, 4'd2, 4'd5, 4'd5, 1'b0);
                checks++;
                if ({seg_n, digit_en_n, frame_start} !== exp_out(k, eu[f], et[f], eh[f])) begin
                    errors++;
                    $display("FAIL basic f=%0d k=%0d got=%h exp=%h", f, k,
                             {seg_n, digit_en_n, frame_start}, exp_out(k, eu[f], et[f], eh[f]));
                end
            end
        end
    endtask

    task automatic test_blanking;
        logic [7:0] eu[3] = '{8'h92, 8'hF8, 8'hF8};
        logic [7:0] et[3] = '{8'h92, 8'hFF, 8'hC0};
        logic [7:0] eh[3] = '{8'hA4, 8'hFF, 8'hC0};
        bit         lz[3] = '{1'b1, 1'b1, 1'b0};
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 18; k++) begin
                tick(f == 0 && k == 0, 4'd0, 4'd0, 4'd7, lz[f]);
                checks++;
                if ({seg_n, digit_en_n, frame_start} !== exp_out(k, eu[f], et[f], eh[f])) begin
                    errors++;
                    $display("FAIL blanking f=%0d k=%0d got=%h exp=%h", f, k,
                             {seg_n, digit_en_n, frame_start}, exp_out(k, eu[f], et[f], eh[f]));
                end
            end
        end
    endtask

    task automatic test_lz_midframe;
        logic [7:0] et;
        for (int k = 0; k < 18; k++) begin
            tick(k == 5, 4'd0, 4'd3, 4'd0, (k < 10));
            et = (k < 10) ? 8'hFF : 8'hC0;
            checks++;
            if ({seg_n, digit_en_n, frame_start} !== exp_out(k, 8'hF8, et, 8'hC0)) begin
                errors++;
                $display("FAIL lz_midframe k=%0d got=%h exp=%h", k,
                         {seg_n, digit_en_n, frame_start}, exp_out(k, 8'hF8, et, 8'hC0));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] eu[3] = '{8'hC0, 8'hB0, 8'h82};
        logic [7:0] et[3] = '{8'hB0, 8'hA4, 8'h92};
        logic [7:0] eh[3] = '{8'hFF, 8'hF9, 8'h99};
        bit         lz[3] = '{1'b1, 1'b0, 1'b0};
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 18; k++) begin
                if (f == 0 && k == 9)
                    tick(1'b1, 4'd1, 4'd2, 4'd3, lz[f]);
                else if (f == 0 && k == 17)
                    tick(1'b1, 4'd4, 4'd5, 4'd6, lz[f]);
                else
                    tick(1'b0, 4'd9, 4'd9, 4'd9, lz[f]);
                checks++;
                if ({seg_n, digit_en_n, frame_start} !== exp_out(k, eu[f], et[f], eh[f])) begin
                    errors++;
                    $display("FAIL back_to_back f=%0d k=%0d got=%h exp=%h", f, k,
                             {seg_n, digit_en_n, frame_start}, exp_out(k, eu[f], et[f], eh[f]));
                end
            end
        end
    endtask

    task automatic test_dash;
        for (int k = 0; k < 18; k++) begin
            tick(k == 1, 4'd12, 4'd0, 4'd0, 1'b0);
        end
        for (int k = 0; k < 18; k++) begin
            tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            checks++;
            if ({seg_n, digit_en_n, frame_start} !== exp_out(k, 8'hC0, 8'hC0, 8'hBF)) begin
                errors++;
                $display("FAIL dash k=%0d got=%h exp=%h", k,
                         {seg_n, digit_en_n, frame_start}, exp_out(k, 8'hC0, 8'hC0, 8'hBF));
            end
        end
    endtask

    task automatic test_mid_reset;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
            checks++;
            if ({seg_n, digit_en_n, frame_start} !== exp_out(k, 8'hC0, 8'hC0, 8'hBF)) begin
                errors++;
                $display("FAIL pre_reset k=%0d got=%h exp=%h", k,
                         {seg_n, digit_en_n, frame_start}, exp_out(k, 8'hC0, 8'hC0, 8'hBF));
            end
        end
        reset = 1'b1;
        tick(1'b1, 4'd9, 4'd9, 4'd9, 1'b0);
        checks++;
        if ({seg_n, digit_en_n, frame_start} !== {8'hFF, 3'b111, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h exp=%h", {seg_n, digit_en_n, frame_start}, {8'hFF, 3'b111, 1'b0});
        end
        tick(1'b1, 4'd9, 4'd9, 4'd9, 1'b0);
        reset = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 18; k++) begin
                tick(1'b0, 4'd8, 4'd8, 4'd8, 1'b0);
                checks++;
                if ({seg_n, digit_en_n, frame_start} !== exp_out(k, 8'hC0, 8'hC0, 8'hC0)) begin
                    errors++;
                    $display("FAIL post_reset f=%0d k=%0d got=%h exp=%h", f, k,
                             {seg_n, digit_en_n, frame_start}, exp_out(k, 8'hC0, 8'hC0, 8'hC0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_lz_midframe();
        test_back_to_back();
        test_dash();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
